// File: rtl/uart_sram_stream_loader.sv
// UART byte stream to SRAM word loader: header skip, byte packing, bounded writes.
// Define UART_SRAM_LOADER_CHECKSUM_EN to add the 16-bit payload Checksum output.
module uart_sram_stream_loader #(
    parameter int ADDR_W         = 18,
    parameter int BYTES_PER_WORD = 2,
    parameter int HEADER_LINES   = 3,
    parameter int BIG_ENDIAN     = 1,
    localparam int DATA_W        = 8 * BYTES_PER_WORD
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Initialize,
    input  logic              Enable,
    input  logic [ADDR_W-1:0] Start_address,
    input  logic [ADDR_W:0]   Max_words,
    input  logic              Rx_empty,
    input  logic [7:0]        Rx_data,
    output logic              Rx_enable,
    output logic              Rx_unload_data,
    output logic [ADDR_W-1:0] SRAM_address,
    output logic [DATA_W-1:0] SRAM_write_data,
    output logic              SRAM_we_n,
    output logic              Busy,
    output logic              Done,
    output logic              Overflow,
    output logic [ADDR_W:0]   Word_count
`ifdef UART_SRAM_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]       Checksum
`endif
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_HDR_WAIT  = 3'd1;
    localparam logic [2:0] S_HDR_ACK   = 3'd2;
    localparam logic [2:0] S_BYTE_WAIT = 3'd3;
    localparam logic [2:0] S_BYTE_ACK  = 3'd4;
    localparam logic [2:0] S_WRITE     = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    localparam int HW = (HEADER_LINES > 0) ? $clog2(HEADER_LINES + 1) : 1;
    localparam int KW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [2:0] S_FIRST = (HEADER_LINES > 0) ? S_HDR_WAIT : S_BYTE_WAIT;

    logic [2:0]        r_state;
    logic [HW-1:0]     r_lf_cnt;
    logic [KW-1:0]     r_k;
    logic [DATA_W-1:0] r_word;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_max;
    logic [ADDR_W:0]   r_cnt;
    logic              r_we_n;
    logic              r_busy;
    logic              r_done;
    logic              r_ovf;
    logic              r_rx_en;
    logic              r_unload;

    logic [KW-1:0]     w_lane;
    logic              w_last_k;
    logic              w_top;
    logic              w_hit;
    logic [ADDR_W:0]   w_cnt_nxt;

    assign w_lane    = (BIG_ENDIAN != 0) ? KW'(BYTES_PER_WORD - 1) - r_k : r_k;
    assign w_last_k  = (r_k == KW'(BYTES_PER_WORD - 1));
    assign w_top     = &r_addr;
    assign w_cnt_nxt = r_cnt + 1'b1;
    assign w_hit     = (r_max != '0) && (w_cnt_nxt == r_max);

    assign Rx_enable       = r_rx_en;
    assign Rx_unload_data  = r_unload;
    assign SRAM_address    = r_addr;
    assign SRAM_write_data = r_word;
    assign SRAM_we_n       = r_we_n;
    assign Busy            = r_busy;
    assign Done            = r_done;
    assign Overflow        = r_ovf;
    assign Word_count      = r_cnt;

`ifdef UART_SRAM_LOADER_CHECKSUM_EN
    logic [15:0] r_csum;
    assign Checksum = r_csum;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_lf_cnt <= '0;
            r_k      <= '0;
            r_word   <= '0;
            r_addr   <= '0;
            r_max    <= '0;
            r_cnt    <= '0;
            r_we_n   <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_rx_en  <= 1'b0;
            r_unload <= 1'b0;
`ifdef UART_SRAM_LOADER_CHECKSUM_EN
            r_csum   <= '0;
`endif
        end else if (Initialize) begin
            r_state  <= S_IDLE;
            r_lf_cnt <= '0;
            r_k      <= '0;
            r_word   <= '0;
            r_addr   <= '0;
            r_max    <= '0;
            r_cnt    <= '0;
            r_we_n   <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_rx_en  <= 1'b0;
            r_unload <= 1'b0;
`ifdef UART_SRAM_LOADER_CHECKSUM_EN
            r_csum   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (Enable) begin
                        r_addr   <= Start_address;
                        r_max    <= Max_words;
                        r_cnt    <= '0;
                        r_lf_cnt <= '0;
                        r_k      <= '0;
                        r_done   <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_busy   <= 1'b1;
                        r_rx_en  <= 1'b1;
`ifdef UART_SRAM_LOADER_CHECKSUM_EN
                        r_csum   <= '0;
`endif
                        r_state  <= S_FIRST;
                    end
                end
                S_HDR_WAIT: begin
                    if (!Rx_empty) begin
                        r_unload <= 1'b1;
                        if (Rx_data == 8'h0A && r_lf_cnt != HW'(HEADER_LINES))
                            r_lf_cnt <= r_lf_cnt + 1'b1;
                        r_state <= S_HDR_ACK;
                    end
                end
                S_HDR_ACK: begin
                    if (Rx_empty) begin
                        r_unload <= 1'b0;
                        r_state  <= (r_lf_cnt == HW'(HEADER_LINES)) ? S_BYTE_WAIT : S_HDR_WAIT;
                    end
                end
                S_BYTE_WAIT: begin
                    if (!Rx_empty) begin
                        r_word[{w_lane, 3'b000} +: 8] <= Rx_data;
                        r_unload <= 1'b1;
`ifdef UART_SRAM_LOADER_CHECKSUM_EN
                        r_csum   <= r_csum + {8'h00, Rx_data};
`endif
                        r_state  <= S_BYTE_ACK;
                    end
                end
                S_BYTE_ACK: begin
                    if (Rx_empty) begin
                        r_unload <= 1'b0;
                        if (w_last_k) begin
                            r_k     <= '0;
                            r_we_n  <= 1'b0;
                            r_state <= S_WRITE;
                        end else begin
                            r_k     <= r_k + 1'b1;
                            r_state <= S_BYTE_WAIT;
                        end
                    end
                end
                S_WRITE: begin
                    // Limit takes priority; top-of-SRAM only flags overflow under a finite limit.
                    r_we_n <= 1'b1;
                    r_cnt  <= w_cnt_nxt;
                    if (w_hit || w_top) begin
                        r_ovf   <= !w_hit && (r_max != '0);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_rx_en <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_addr  <= r_addr + 1'b1;
                        r_state <= S_BYTE_WAIT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_sram_stream_loader.sv
// Scoreboard bench for uart_sram_stream_loader: two configurations share one Rx feed.
// Checksum test runs only when UART_SRAM_LOADER_CHECKSUM_EN is defined.
module tb_uart_sram_stream_loader;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Initialize = 1'b0;
    logic        en0 = 1'b0;
    logic        en1 = 1'b0;
    logic [17:0] Start_address = '0;
    logic [18:0] Max_words = '0;
    logic        Rx_empty = 1'b1;
    logic [7:0]  Rx_data = '0;
    logic        sel = 1'b0;

    logic        u0_rx_en, u0_unload, u0_we_n, u0_busy, u0_done, u0_ovf;
    logic [17:0] u0_addr;
    logic [15:0] u0_data;
    logic [18:0] u0_cnt;
    logic        u1_rx_en, u1_unload, u1_we_n, u1_busy, u1_done, u1_ovf;
    logic [17:0] u1_addr;
    logic [31:0] u1_data;
    logic [18:0] u1_cnt;
`ifdef UART_SRAM_LOADER_CHECKSUM_EN
    logic [15:0] u0_csum, u1_csum;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    bit prev0 = 1'b0;
    bit prev1 = 1'b0;

    wire w_unload = sel ? u1_unload : u0_unload;

    always #5 clk = ~clk;

    uart_sram_stream_loader #(
        .ADDR_W(18), .BYTES_PER_WORD(2), .HEADER_LINES(3), .BIG_ENDIAN(1)
    ) u0 (
        .Clock(clk), .Reset(Reset), .Initialize(Initialize), .Enable(en0),
        .Start_address(Start_address), .Max_words(Max_words),
        .Rx_empty(Rx_empty), .Rx_data(Rx_data),
        .Rx_enable(u0_rx_en), .Rx_unload_data(u0_unload),
        .SRAM_address(u0_addr), .SRAM_write_data(u0_data), .SRAM_we_n(u0_we_n),
        .Busy(u0_busy), .Done(u0_done), .Overflow(u0_ovf), .Word_count(u0_cnt)
`ifdef UART_SRAM_LOADER_CHECKSUM_EN
        , .Checksum(u0_csum)
`endif
    );

    uart_sram_stream_loader #(
        .ADDR_W(18), .BYTES_PER_WORD(4), .HEADER_LINES(0), .BIG_ENDIAN(0)
    ) u1 (
        .Clock(clk), .Reset(Reset), .Initialize(Initialize), .Enable(en1),
        .Start_address(Start_address), .Max_words(Max_words),
        .Rx_empty(Rx_empty), .Rx_data(Rx_data),
        .Rx_enable(u1_rx_en), .Rx_unload_data(u1_unload),
        .SRAM_address(u1_addr), .SRAM_write_data(u1_data), .SRAM_we_n(u1_we_n),
        .Busy(u1_busy), .Done(u1_done), .Overflow(u1_ovf), .Word_count(u1_cnt)
`ifdef UART_SRAM_LOADER_CHECKSUM_EN
        , .Checksum(u1_csum)
`endif
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Write monitors: every we_n-low sample must match the head of its queue.
    always @(negedge clk) begin
        if (u0_we_n === 1'b0) begin
            check("u0_we_single_cycle", 64'(prev0), 64'd0);
            check("u0_write_expected", 64'(q0.size() != 0), 64'd1);
            if (q0.size() != 0)
                check("u0_write", {14'b0, u0_addr, 16'b0, u0_data}, q0.pop_front());
        end
        prev0 = (u0_we_n === 1'b0);
        if (u1_we_n === 1'b0) begin
            check("u1_we_single_cycle", 64'(prev1), 64'd0);
            check("u1_write_expected", 64'(q1.size() != 0), 64'd1);
            if (q1.size() != 0)
                check("u1_write", {14'b0, u1_addr, u1_data}, q1.pop_front());
        end
        prev1 = (u1_we_n === 1'b0);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input int hold, output bit ok);
        ok = 1'b0;
        Rx_data  = b;
        Rx_empty = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (w_unload) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) tick(hold);
        Rx_empty = 1'b1;
        if (ok) begin
            for (int i = 0; i < 40; i++) begin
                tick(1);
                if (!w_unload) break;
            end
        end
    endtask

    task automatic send_chk(input logic [7:0] b, input int hold);
        bit ok;
        send(b, hold, ok);
        check("rx_byte_acked", 64'(ok), 64'd1);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_chk(s[i], 0);
    endtask

    task automatic start0(input logic [17:0] a, input logic [18:0] m);
        Start_address = a;
        Max_words     = m;
        en0 = 1'b1;
        tick(1);
        en0 = 1'b0;
        check("u0_start_busy", 64'(u0_busy), 64'd1);
        check("u0_start_addr", 64'(u0_addr), 64'(a));
    endtask

    initial begin : wdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        bit ok;
        int nb;
        tick(2);
        check("rst_we_n", 64'(u0_we_n), 64'd1);
        check("rst_busy", 64'(u0_busy), 64'd0);
        check("rst_rx_en", 64'(u0_rx_en), 64'd0);
        check("rst_cnt", 64'(u0_cnt), 64'd0);
        Reset = 1'b0;
        tick(2);

        // 1: PPM-style header, big-endian 16-bit words
        sel = 1'b0;
        start0(18'h100, 19'd2);
        check("t1_rx_en", 64'(u0_rx_en), 64'd1);
        send_str("P6\n4 4\n255\n");
        q0.push_back({14'b0, 18'h100, 32'h1234});
        q0.push_back({14'b0, 18'h101, 32'h5678});
        send_chk(8'h12, 0); send_chk(8'h34, 0);
        send_chk(8'h56, 0); send_chk(8'h78, 0);
        tick(2);
        check("t1_done", 64'(u0_done), 64'd1);
        check("t1_busy", 64'(u0_busy), 64'd0);
        check("t1_count", 64'(u0_cnt), 64'd2);
        check("t1_ovf", 64'(u0_ovf), 64'd0);

        // 2: little-endian 32-bit words, no header
        sel = 1'b1;
        Start_address = 18'h20;
        Max_words = 19'd1;
        en1 = 1'b1;
        tick(1);
        en1 = 1'b0;
        q1.push_back({14'b0, 18'h20, 32'h04030201});
        send_chk(8'h01, 0); send_chk(8'h02, 0);
        send_chk(8'h03, 0); send_chk(8'h04, 0);
        tick(2);
        check("t2_done", 64'(u1_done), 64'd1);
        check("t2_count", 64'(u1_cnt), 64'd1);

        // 3: runs into top of SRAM with a finite limit
        sel = 1'b0;
        start0(18'h3FFFE, 19'd5);
        send_str("\n\n\n");
        q0.push_back({14'b0, 18'h3FFFE, 32'hA1A2});
        q0.push_back({14'b0, 18'h3FFFF, 32'hB1B2});
        nb = 0;
        for (int i = 0; i < 12; i++) begin
            logic [7:0] b;
            b = (i[1] ? 8'hB0 : 8'hA0) + 8'((i % 2) + 1);
            send(b, 0, ok);
            if (!ok) break;
            nb++;
        end
        check("t3_bytes_taken", 64'(nb), 64'd4);
        check("t3_ovf", 64'(u0_ovf), 64'd1);
        check("t3_count", 64'(u0_cnt), 64'd2);
        check("t3_rx_en", 64'(u0_rx_en), 64'd0);
        check("t3_done", 64'(u0_done), 64'd1);

        // 3b: unlimited load ending at top is not an overflow
        start0(18'h3FFFF, 19'd0);
        send_str("\n\n\n");
        q0.push_back({14'b0, 18'h3FFFF, 32'h9ABC});
        send_chk(8'h9A, 0); send_chk(8'hBC, 0);
        tick(2);
        check("t3b_done", 64'(u0_done), 64'd1);
        check("t3b_ovf", 64'(u0_ovf), 64'd0);
        check("t3b_count", 64'(u0_cnt), 64'd1);
        send(8'h55, 0, ok);
        check("t3b_no_more_bytes", 64'(ok), 64'd0);

        // 4: Initialize mid-word, together with Enable
        start0(18'h40, 19'd3);
        send_str("\n\n\n");
        send_chk(8'hAB, 0);
        Initialize = 1'b1;
        en0 = 1'b1;
        tick(1);
        Initialize = 1'b0;
        en0 = 1'b0;
        check("t4_we_n", 64'(u0_we_n), 64'd1);
        check("t4_busy", 64'(u0_busy), 64'd0);
        check("t4_done", 64'(u0_done), 64'd0);
        check("t4_ovf", 64'(u0_ovf), 64'd0);
        check("t4_count", 64'(u0_cnt), 64'd0);
        check("t4_addr", 64'(u0_addr), 64'd0);
        check("t4_data", 64'(u0_data), 64'd0);
        check("t4_rx_en", 64'(u0_rx_en), 64'd0);
        check("t4_unload", 64'(u0_unload), 64'd0);
        start0(18'h50, 19'd1);
        send_str("\n\n\n");
        q0.push_back({14'b0, 18'h50, 32'hCDEF});
        send_chk(8'hCD, 0); send_chk(8'hEF, 0);
        tick(2);
        check("t4_reload_done", 64'(u0_done), 64'd1);

        // 5: long Rx_empty low during ACK, then reset during a write
        start0(18'h60, 19'd0);
        send_str("\n\n\n");
        q0.push_back({14'b0, 18'h60, 32'h1122});
        send_chk(8'h11, 5); send_chk(8'h22, 5);
        send_chk(8'h33, 0); send_chk(8'h44, 0);
        check("t5_we_low", 64'(u0_we_n), 64'd0);
        #1 Reset = 1'b1;
        #1 check("t5_we_async", 64'(u0_we_n), 64'd1);
        tick(2);
        check("t5_busy", 64'(u0_busy), 64'd0);
        Reset = 1'b0;
        tick(1);

`ifdef UART_SRAM_LOADER_CHECKSUM_EN
        // 6: checksum over payload only
        start0(18'h70, 19'd2);
        send_str("A\n\n\n");
        q0.push_back({14'b0, 18'h70, 32'hFFFF});
        q0.push_back({14'b0, 18'h71, 32'h0100});
        send_chk(8'hFF, 0); send_chk(8'hFF, 0);
        send_chk(8'h01, 0); send_chk(8'h00, 0);
        tick(2);
        check("t6_checksum", 64'(u0_csum), 64'h01FF);
        check("t6_done", 64'(u0_done), 64'd1);
`endif

        tick(3);
        check("q0_drained", 64'(q0.size()), 64'd0);
        check("q1_drained", 64'(q1.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
